// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM state encoding, control opcodes and word width.
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] VALID = 2'd2;
  localparam logic [1:0] ERROR = 2'd3;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: sequential, beq/bne relative target, or j/jal pseudo-direct target.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] pc_plus4,
  input  logic               branch,
  input  logic               bne,
  input  logic               jump,
  input  logic               zero,
  input  logic [INSTR_W-1:0] imm_sext,
  input  logic [25:0]        jtarget,
  output logic [INSTR_W-1:0] next_pc
);

  logic signed [INSTR_W-1:0] br_off;
  logic [INSTR_W-1:0]        br_target;
  logic                      taken;

  // Word offset to byte offset; the add wraps modulo 2^32.
  assign br_off    = $signed(imm_sext) <<< 2;
  assign br_target = pc_plus4 + $unsigned(br_off);
  assign taken     = branch & (zero ^ bne);

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], jtarget, 2'b00};
    end else if (taken) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction fetch stage: PC register, imem req/ready handshake with timeout, one instruction presented to decode.
module fetch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic        bne,
  input  logic        jump,
  input  logic        zero,
  input  logic [31:0] imm_sext,
  input  logic [25:0] jtarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        imem_err
);

  localparam logic [3:0] TIMEOUT_CNT = 4'(TIMEOUT);

  logic [1:0]         state;
  logic [INSTR_W-1:0] pc;
  logic [INSTR_W-1:0] next_pc;
  logic [3:0]         wait_cnt;

  assign pc_out   = pc;
  assign pc_plus4 = pc + 32'd4;

  next_pc_sel u_next_pc_sel (
    .pc_plus4 (pc_plus4),
    .branch   (branch),
    .bne      (bne),
    .jump     (jump),
    .zero     (zero),
    .imm_sext (imm_sext),
    .jtarget  (jtarget),
    .next_pc  (next_pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_err    <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        FETCH: begin
          imem_req  <= 1'b1;
          imem_addr <= pc;
          wait_cnt  <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // A response arriving on the final allowed cycle still beats the timeout.
          if (imem_ready) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= VALID;
          end else if (wait_cnt + 4'd1 == TIMEOUT_CNT) begin
            imem_err <= 1'b1;
            imem_req <= 1'b0;
            state    <= ERROR;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        VALID: begin
          if (!stall) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            state       <= FETCH;
          end
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
